// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter feeding one shared serial Divider, one job in flight.
// Optional DIV_TIMEOUT_EN adds a WAIT/RECV watchdog that answers with rsp_err and all-ones data.
module div_scheduler #(
  parameter int NIB = 4,
  parameter int RES_W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [4*NIB-1:0] req0_data,
  input  logic [4*NIB-1:0] req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             in_valid,
  output logic [3:0]       in_data,
  input  logic             out_valid,
  input  logic             out_data,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err
);
  localparam int NW = $clog2(NIB + 1);
  localparam int BW = $clog2(RES_W + 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;
  state_t state;
  logic [4*NIB-1:0] cap, sh, sel;
  logic [NW-1:0] ncnt;
  logic [BW-1:0] bcnt;
  logic [RES_W-1:0] res, res_nx;
  logic pri, owner, grant0, grant1, last_bit;
`ifdef DIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign rsp_err = 1'b0;
`endif
  // pri names the requester preferred on a tie; it flips away from whoever was just granted
  always_comb begin
    grant0 = state == IDLE && req0_valid && (!req1_valid || !pri);
    grant1 = state == IDLE && req1_valid && (!req0_valid || pri);
    sel = grant1 ? req1_data : req0_data;
    sh = cap << 4;
    res_nx = (res << 1) | RES_W'(out_data);
    last_bit = (state == WAIT || state == RECV) && out_valid && bcnt == BW'(RES_W - 1);
  end
  assign req0_ready = rst_n && grant0;
  assign req1_ready = rst_n && grant1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cap <= '0;
      ncnt <= '0;
      bcnt <= '0;
      res <= '0;
      pri <= 1'b0;
      owner <= 1'b0;
      in_valid <= 1'b0;
      in_data <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
`ifdef DIV_TIMEOUT_EN
      rsp_err <= 1'b0;
      tcnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (grant0 || grant1) begin
          state <= SEND;
          owner <= grant1;
          pri <= grant0;
          cap <= sel;
          ncnt <= '0;
          in_valid <= 1'b1;
          in_data <= sel[4*NIB-1 -: 4];
        end
        SEND: if (ncnt == NW'(NIB - 1)) begin
          state <= WAIT;
          ncnt <= '0;
          in_valid <= 1'b0;
          in_data <= '0;
`ifdef DIV_TIMEOUT_EN
          tcnt <= '0;
`endif
        end else begin
          ncnt <= ncnt + NW'(1);
          cap <= sh;
          in_data <= sh[4*NIB-1 -: 4];
        end
        WAIT, RECV: begin
          if (out_valid) begin
            res <= res_nx;
            bcnt <= bcnt + BW'(1);
            state <= RECV;
          end
          if (last_bit) begin
            state <= RESP;
            bcnt <= '0;
            rsp_valid <= 1'b1;
            rsp_id <= owner;
            rsp_data <= res_nx;
`ifdef DIV_TIMEOUT_EN
            rsp_err <= 1'b0;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= RESP;
            bcnt <= '0;
            rsp_valid <= 1'b1;
            rsp_id <= owner;
            rsp_data <= '1;
            rsp_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
`endif
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: randomized bench with a behavioural Divider stub and response scoreboard.
// Build with DIV_TIMEOUT_EN defined to exercise the watchdog path.
module tb_div_scheduler;
  localparam int NIB = 4, RES_W = 8, TIMEOUT = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, in_valid, out_valid, out_data, rsp_valid, rsp_id, rsp_err;
  logic [3:0] in_data;
  logic [7:0] rsp_data;
  int cyc = 0, errors = 0, checks = 0;
  int acc_cyc[$], acc_id[$], rsp_cyc[$], rsp_idq[$];
  logic [15:0] acc_data[$];
  logic [7:0] rsp_dq[$];
  logic rsp_eq[$];
  logic [3:0] nib_q[$];
  int idle_data_bad = 0, dual_ready = 0, gap_mode = 0, start_dly = 0, bits_sent = 0;
  bit silent = 0, glitch = 0;

  div_scheduler #(.NIB(NIB), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub's transfer function; the scheduler must relay it untouched
  function automatic logic [7:0] div_fn(input logic [15:0] op);
    return op[15:8] ^ op[7:0] ^ 8'h83;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (req0_ready && req1_ready) dual_ready++;
    if (req0_ready) begin
      acc_cyc.push_back(cyc); acc_id.push_back(0); acc_data.push_back(req0_data);
    end else if (req1_ready) begin
      acc_cyc.push_back(cyc); acc_id.push_back(1); acc_data.push_back(req1_data);
    end
    if (in_valid) nib_q.push_back(in_data);
    else if (in_data !== 4'h0) idle_data_bad++;
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc); rsp_idq.push_back(int'(rsp_id));
      rsp_dq.push_back(rsp_data); rsp_eq.push_back(rsp_err);
    end
  end

  // Divider: gathers NIB nibbles, needs one cycle to compute, then streams RES_W bits MSB first
  initial begin
    logic [15:0] op;
    logic [7:0] r;
    int n, gap;
    out_valid = 1'b0;
    out_data = 1'b0;
    forever begin
      op = '0;
      n = 0;
      while (n < NIB) begin
        @(negedge clk);
        if (!rst_n) n = 0;
        else if (in_valid) begin op = {op[11:0], in_data}; n++; end
        tick();
        out_valid = glitch && n > 0 && n < NIB;
        out_data = out_valid;
      end
      if (!silent) begin
        r = div_fn(op);
        repeat (1 + start_dly) tick();
        for (int i = RES_W - 1; i >= 0; i--) begin
          out_valid = 1'b1;
          out_data = r[i];
          bits_sent++;
          tick();
          if (!rst_n) break;
          if (i > 0) begin
            gap = gap_mode == 2 ? int'($urandom_range(0, 2)) : gap_mode;
            if (gap > 0) begin out_valid = 1'b0; repeat (gap) tick(); end
          end
        end
        out_valid = 1'b0;
        out_data = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete(); acc_data.delete(); nib_q.delete();
    rsp_cyc.delete(); rsp_idq.delete(); rsp_dq.delete(); rsp_eq.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input int id, input logic [15:0] d, output bit ok);
    ok = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; end
    else begin req1_valid = 1'b1; req1_data = d; end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = id == 0 ? req0_ready : req1_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_cyc.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, in_valid, in_data, rsp_valid, rsp_id, rsp_err, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {req0_ready, req1_ready, in_valid, in_data, rsp_valid, rsp_id, rsp_err, rsp_data});
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] got;
    clear_logs();
    send(0, 16'h1234, ok);
    wait_rsp(1, 200);
    checks++;
    if (!ok || rsp_cyc.size() != 1) begin
      errors++; $display("FAIL basic_count: accepted=%0d responses=%0d required 1/1", ok, rsp_cyc.size());
    end else begin
      got = '0;
      foreach (nib_q[i]) got = {got[11:0], nib_q[i]};
      checks++;
      if (nib_q.size() != 4 || got !== 16'h1234) begin
        errors++; $display("FAIL basic_nibbles: got %0d nibbles %h required 4 nibbles 1234", nib_q.size(), got);
      end
      checks++;
      if (rsp_idq[0] != 0 || rsp_dq[0] !== 8'hA5 || rsp_eq[0] !== 1'b0) begin
        errors++; $display("FAIL basic_rsp: id=%0d data=%h err=%b required id=0 data=a5 err=0", rsp_idq[0], rsp_dq[0], rsp_eq[0]);
      end
      checks++;
      if (rsp_cyc[0] - acc_cyc[0] != NIB + RES_W + 2) begin
        errors++; $display("FAIL basic_latency: got %0d required %0d", rsp_cyc[0] - acc_cyc[0], NIB + RES_W + 2);
      end
    end
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (rsp_cyc.size() != 1 || rsp_valid !== 1'b0 || rsp_data !== 8'hA5 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL basic_hold: responses=%0d valid=%b data=%h id=%b required 1/0/a5/0", rsp_cyc.size(), rsp_valid, rsp_data, rsp_id);
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit r0, r1;
    apply_reset();
    clear_logs();
    gap_mode = 2;
    req0_data = 16'($urandom);
    req1_data = 16'($urandom);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3000 && acc_cyc.size() < 6; i++) begin
      @(negedge clk);
      r0 = req0_ready;
      r1 = req1_ready;
      start_dly = $urandom_range(0, 3);
      tick();
      if (r0) req0_data = 16'($urandom);
      if (r1) req1_data = 16'($urandom);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(6, 300);
    gap_mode = 0;
    start_dly = 0;
    checks++;
    if (acc_cyc.size() != 6 || rsp_cyc.size() != 6) begin
      errors++; $display("FAIL rr_count: accepts=%0d responses=%0d required 6/6", acc_cyc.size(), rsp_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_id[i] != i % 2) begin
          errors++; $display("FAIL rr_grant[%0d]: got %0d required %0d", i, acc_id[i], i % 2);
        end
        checks++;
        if (rsp_idq[i] != acc_id[i] || rsp_dq[i] !== div_fn(acc_data[i])) begin
          errors++; $display("FAIL rr_rsp[%0d]: id=%0d data=%h required id=%0d data=%h", i, rsp_idq[i], rsp_dq[i], acc_id[i], div_fn(acc_data[i]));
        end
        if (i < 5) begin
          checks++;
          if (acc_cyc[i+1] <= rsp_cyc[i]) begin
            errors++; $display("FAIL rr_busy_accept[%0d]: accept at %0d required after response at %0d", i, acc_cyc[i+1], rsp_cyc[i]);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    logic [15:0] d;
    d = 16'($urandom);
    clear_logs();
    send(1, d, ok);
    wait_rsp(1, 200);
    gap_mode = 1;
    send(0, d, ok);
    wait_rsp(2, 300);
    gap_mode = 0;
    checks++;
    if (rsp_cyc.size() != 2) begin
      errors++; $display("FAIL gap_count: responses=%0d required 2", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_dq[1] !== rsp_dq[0] || rsp_dq[1] !== div_fn(d)) begin
        errors++; $display("FAIL gap_data: gapped=%h gap_free=%h required %h", rsp_dq[1], rsp_dq[0], div_fn(d));
      end
      checks++;
      if (rsp_cyc[1] - acc_cyc[1] != NIB + 3 + (RES_W - 1) * 2) begin
        errors++; $display("FAIL gap_latency: got %0d required %0d", rsp_cyc[1] - acc_cyc[1], NIB + 3 + (RES_W - 1) * 2);
      end
    end
  endtask

  task automatic test_glitch();
    bit ok;
    logic [15:0] d;
    d = 16'($urandom);
    clear_logs();
    glitch = 1;
    send(1, d, ok);
    wait_rsp(1, 200);
    glitch = 0;
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL glitch_count: responses=%0d required 1", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_dq[0] !== div_fn(d) || rsp_idq[0] != 1) begin
        errors++; $display("FAIL glitch_rsp: data=%h id=%0d required data=%h id=1", rsp_dq[0], rsp_idq[0], div_fn(d));
      end
      checks++;
      if (rsp_cyc[0] - acc_cyc[0] != NIB + RES_W + 2) begin
        errors++; $display("FAIL glitch_latency: got %0d required %0d", rsp_cyc[0] - acc_cyc[0], NIB + RES_W + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] d;
    clear_logs();
    bits_sent = 0;
    send(0, 16'($urandom), ok);
    for (int i = 0; i < 200 && bits_sent < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_valid, in_data, rsp_valid, rsp_id, rsp_err, rsp_data} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b required all zero", {in_valid, in_data, rsp_valid, rsp_id, rsp_err, rsp_data});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    checks++;
    if (rsp_cyc.size() != 0) begin
      errors++; $display("FAIL midreset_no_rsp: responses=%0d required 0", rsp_cyc.size());
    end
    clear_logs();
    d = 16'($urandom);
    send(1, d, ok);
    wait_rsp(1, 200);
    checks++;
    if (rsp_cyc.size() != 1 || rsp_idq[0] != 1 || rsp_dq[0] !== div_fn(d) || rsp_cyc[0] - acc_cyc[0] != NIB + RES_W + 2) begin
      errors++; $display("FAIL midreset_next_job: responses=%0d id=%0d data=%h required 1 response id=1 data=%h latency %0d",
                         rsp_cyc.size(), rsp_cyc.size() ? rsp_idq[0] : -1, rsp_cyc.size() ? rsp_dq[0] : 8'h0, div_fn(d), NIB + RES_W + 2);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    silent = 1;
    send(0, 16'($urandom), ok);
`ifdef DIV_TIMEOUT_EN
    wait_rsp(1, 200);
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL timeout_count: responses=%0d required 1", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_eq[0] !== 1'b1 || rsp_dq[0] !== 8'hFF || rsp_idq[0] != 0) begin
        errors++; $display("FAIL timeout_rsp: err=%b data=%h id=%0d required err=1 data=ff id=0", rsp_eq[0], rsp_dq[0], rsp_idq[0]);
      end
      checks++;
      if (rsp_cyc[0] - acc_cyc[0] != NIB + TIMEOUT + 1) begin
        errors++; $display("FAIL timeout_latency: got %0d required %0d", rsp_cyc[0] - acc_cyc[0], NIB + TIMEOUT + 1);
      end
    end
`else
    repeat (300) tick();
    checks++;
    if (rsp_cyc.size() != 0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL no_timeout: responses=%0d err=%b required 0/0", rsp_cyc.size(), rsp_err);
    end
    req1_valid = 1'b1;
    req1_data = 16'($urandom);
    repeat (20) tick();
    req1_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 1) begin
      errors++; $display("FAIL stuck_accept: accepts=%0d required 1", acc_cyc.size());
    end
    apply_reset();
`endif
    silent = 0;
  endtask

  task automatic test_random();
    bit ok;
    int ids[$];
    logic [15:0] ds[$];
    clear_logs();
    gap_mode = 2;
    for (int j = 0; j < 8; j++) begin
      ids.push_back($urandom_range(0, 1));
      ds.push_back(16'($urandom));
      start_dly = $urandom_range(0, 3);
      send(ids[j], ds[j], ok);
      wait_rsp(j + 1, 300);
      repeat ($urandom_range(0, 2)) tick();
    end
    gap_mode = 0;
    start_dly = 0;
    checks++;
    if (rsp_cyc.size() != 8) begin
      errors++; $display("FAIL rand_count: responses=%0d required 8", rsp_cyc.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (rsp_idq[j] != ids[j] || rsp_dq[j] !== div_fn(ds[j]) || rsp_eq[j] !== 1'b0) begin
          errors++; $display("FAIL rand_rsp[%0d]: id=%0d data=%h err=%b required id=%0d data=%h err=0", j, rsp_idq[j], rsp_dq[j], rsp_eq[j], ids[j], div_fn(ds[j]));
        end
      end
    end
  endtask

  task automatic test_idle_outputs();
    checks++;
    if (idle_data_bad != 0 || dual_ready != 0) begin
      errors++; $display("FAIL idle_outputs: in_data nonzero while idle %0d times, dual ready %0d times, required 0/0", idle_data_bad, dual_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_gaps();
    test_glitch();
    test_reset_mid();
    test_timeout();
    test_random();
    test_idle_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
